// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake of the register scoreboard: ID issue info and WB retire in, stall/status out.
interface reg_scoreboard_if;
    logic        id_valid;
    logic [4:0]  id_Rs;
    logic [4:0]  id_Rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_RegWrite;
    logic        id_long;
    logic [4:0]  id_Write_register;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_Write_register;
    logic        id_stall;
    logic [31:0] pending;
    logic        busy;
    logic        sb_error;

    modport master (
        output id_valid, id_Rs, id_Rt, id_use_rs, id_use_rt, id_RegWrite, id_long,
               id_Write_register, flush, wb_valid, wb_Write_register,
        input  id_stall, pending, busy, sb_error
    );

    modport slave (
        input  id_valid, id_Rs, id_Rt, id_use_rs, id_use_rt, id_RegWrite, id_long,
               id_Write_register, flush, wb_valid, wb_Write_register,
        output id_stall, pending, busy, sb_error
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters for long-latency results; stalls decode on unforwardable hazards.
// Define SB_BYPASS_EN to let a reader proceed in the cycle its last outstanding write retires.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  sb
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Entry 0 is only ever cleared, so it reads as zero forever.
    logic [CNT_W-1:0] cnt [32];
    logic             err;

    logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_wd, cnt_wb;
    logic             byp_rs, byp_rt;
    logic             haz_rs, haz_rt, haz_cap;
    logic             long_wr, stall, issue, retire, same;

    assign cnt_rs = cnt[sb.id_Rs];
    assign cnt_rt = cnt[sb.id_Rt];
    assign cnt_wd = cnt[sb.id_Write_register];
    assign cnt_wb = cnt[sb.wb_Write_register];

`ifdef SB_BYPASS_EN
    // Last outstanding write retiring now: the WB forwarding path supplies the value.
    assign byp_rs = sb.wb_valid && (sb.wb_Write_register == sb.id_Rs) && (cnt_rs == ONE);
    assign byp_rt = sb.wb_valid && (sb.wb_Write_register == sb.id_Rt) && (cnt_rt == ONE);
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    assign haz_rs  = sb.id_use_rs && (sb.id_Rs != 5'd0) && (cnt_rs != '0) && !byp_rs;
    assign haz_rt  = sb.id_use_rt && (sb.id_Rt != 5'd0) && (cnt_rt != '0) && !byp_rt;
    assign long_wr = sb.id_RegWrite && sb.id_long && (sb.id_Write_register != 5'd0);
    assign haz_cap = long_wr && (cnt_wd == MAX);

    assign stall  = reset && sb.id_valid && !sb.flush && (haz_rs || haz_rt || haz_cap);
    assign issue  = reset && sb.id_valid && !stall && !sb.flush && long_wr;
    assign retire = sb.wb_valid && (sb.wb_Write_register != 5'd0);
    // Issue and retire of one register cancel out, even from zero.
    assign same   = issue && retire && (sb.id_Write_register == sb.wb_Write_register);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            if (issue && !same)
                cnt[sb.id_Write_register] <= cnt_wd + ONE;
            if (retire && !same) begin
                if (cnt_wb != '0) cnt[sb.wb_Write_register] <= cnt_wb - ONE;
                else              err <= 1'b1;
            end
        end
    end

    always_comb begin
        sb.pending = '0;
        for (int r = 1; r < 32; r++) sb.pending[r] = (cnt[r] != '0);
    end

    assign sb.busy     = |sb.pending;
    assign sb.id_stall = stall;
    assign sb.sb_error = err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed vector table plus randomized traffic checked against a counting model of the scoreboard rules.
module tb_reg_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_scoreboard_if bus ();
    reg_scoreboard #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .sb(bus));

    typedef struct {
        bit        rst;
        bit        v;
        bit [4:0]  rs;
        bit        urs;
        bit [4:0]  rt;
        bit        urt;
        bit        rw;
        bit        lg;
        bit [4:0]  wd;
        bit        fl;
        bit        wv;
        bit [4:0]  wr;
        bit        stall;
        bit [31:0] pend;
        bit        err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cm [32];
    bit em;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] b(int n);
        return 32'(1) << n;
    endfunction

    function automatic vec_t mk(bit rst, bit v, bit [4:0] rs, bit urs, bit [4:0] rt, bit urt,
                                bit rw, bit lg, bit [4:0] wd, bit fl, bit wv, bit [4:0] wr,
                                bit stall, bit [31:0] pend, bit err);
        vec_t t;
        t.rst = rst; t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt;
        t.rw = rw; t.lg = lg; t.wd = wd; t.fl = fl; t.wv = wv; t.wr = wr;
        t.stall = stall; t.pend = pend; t.err = err;
        return t;
    endfunction

    function automatic bit m_haz(bit u, bit [4:0] r, bit wv, bit [4:0] wr);
        return u && r != 0 && cm[r] > 0 && !(BYP && wv && wr == r && cm[r] == 1);
    endfunction

    function automatic bit m_stall(vec_t t);
        if (!t.rst) return 1'b0;
        return t.v && !t.fl && (m_haz(t.urs, t.rs, t.wv, t.wr) || m_haz(t.urt, t.rt, t.wv, t.wr) ||
                                (t.rw && t.lg && t.wd != 0 && cm[t.wd] == MAXC));
    endfunction

    function automatic bit [31:0] m_pend();
        bit [31:0] p = '0;
        for (int i = 1; i < 32; i++) p[i] = (cm[i] != 0);
        return p;
    endfunction

    task automatic m_update(vec_t t, bit st);
        bit iss, ret;
        if (!t.rst) begin
            for (int i = 0; i < 32; i++) cm[i] = 0;
            em = 1'b0;
            return;
        end
        iss = t.v && !st && !t.fl && t.rw && t.lg && t.wd != 0;
        ret = t.wv && t.wr != 0;
        if (iss && ret && t.wd == t.wr) return;
        if (iss) cm[t.wd]++;
        if (ret) begin
            if (cm[t.wr] > 0) cm[t.wr]--;
            else em = 1'b1;
        end
    endtask

    task automatic drive(vec_t t);
        reset                 = t.rst;
        bus.id_valid          = t.v;
        bus.id_Rs             = t.rs;
        bus.id_use_rs         = t.urs;
        bus.id_Rt             = t.rt;
        bus.id_use_rt         = t.urt;
        bus.id_RegWrite       = t.rw;
        bus.id_long           = t.lg;
        bus.id_Write_register = t.wd;
        bus.flush             = t.fl;
        bus.wb_valid          = t.wv;
        bus.wb_Write_register = t.wr;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step(vec_t t, bit tbl, string tag);
        bit        st;
        bit [31:0] pe;
        drive(t);
        @(negedge clk);
        st = m_stall(t);
        pe = m_pend();
        if (tbl) begin
            check($sformatf("%s id_stall", tag), bus.id_stall, t.stall);
            check($sformatf("%s pending", tag), bus.pending, t.pend);
            check($sformatf("%s sb_error", tag), bus.sb_error, t.err);
        end else begin
            check($sformatf("%s id_stall", tag), bus.id_stall, st);
            check($sformatf("%s pending", tag), bus.pending, pe);
            check($sformatf("%s sb_error", tag), bus.sb_error, em);
        end
        check($sformatf("%s busy", tag), bus.busy, |pe);
        @(posedge clk);
        #1;
        m_update(t, st);
    endtask

    initial begin
        vec_t tbl [$];
        vec_t t;
        for (int i = 0; i < 32; i++) cm[i] = 0;
        em = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;

        // reset held with random traffic
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(0, 1, 5'($urandom), 1, 5'($urandom), 1, 1, 1, 5'($urandom), 0,
                             1'($urandom), 5'($urandom), 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // load-use on r8, retire in the fourth cycle
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(8), 0));
        tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, b(8), 0));
        tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 8, !BYP, b(8), 0));
        tbl.push_back(mk(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // capacity on r5
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, b(5), 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, b(5), 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 1, b(5), 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 1, 5, 1, b(5), 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, b(5), 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, b(5), 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, b(5), 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, b(5), 0));
        // simultaneous issue/retire: same register, then different registers
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 9, 0, 1, 9, 0, b(9), 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, b(9), 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 3, 0, 1, 4, 0, b(9) | b(4), 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, b(9) | b(3), 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, b(3), 0));
        // register 0 and flush
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // retire with nothing pending, then reset mid-operation
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0, 0, b(2), 1));
        tbl.push_back(mk(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, b(2) | b(7), 1));
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, b(2) | b(7), 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // same-register issue/retire from zero raises no error
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 10, 0, 1, 10, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

        for (int i = 0; i < 3000; i++) begin
            t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            t.rst = ($urandom_range(0, 99) != 0);
            t.v   = ($urandom_range(0, 3) != 0);
            t.rs  = 5'($urandom_range(0, 7));
            t.urs = 1'($urandom);
            t.rt  = 5'($urandom_range(0, 7));
            t.urt = 1'($urandom);
            t.rw  = 1'($urandom);
            t.lg  = ($urandom_range(0, 2) != 0);
            t.wd  = 5'($urandom_range(0, 7));
            t.fl  = ($urandom_range(0, 9) == 0);
            t.wv  = ($urandom_range(0, 2) == 0);
            t.wr  = 5'($urandom_range(0, 7));
            step(t, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks destination registers of in-flight long-latency writes (loads, multi-cycle mul/div) and stalls the decode stage when an instruction reads a register whose value cannot yet be forwarded. It sits beside the ID/EX pipeline register. It is the producer-side counterpart of the EX forwarding logic: forwarding resolves hazards it can bypass, and this block holds decode on those it cannot. Issue events come from ID and retire events come from WB.

## Interface
- CNT_W, 2, width of each per-register pending counter; MAX = 2^CNT_W − 1 outstanding writes per register
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- id_valid  input  1  valid instruction in ID
- id_Rs, id_Rt  input  5  source register numbers
- id_use_rs, id_use_rt  input  1  instruction actually reads Rs / Rt
- id_RegWrite  input  1  instruction writes a register
- id_long  input  1  write is long-latency and must be tracked
- id_Write_register  input  5  destination register
- flush  input  1  kill the ID instruction this cycle (branch/jump)
- wb_valid  input  1  a tracked write retires this cycle
- wb_Write_register  input  5  register being retired
- id_stall  output  1  hold PC and IF/ID and insert a bubble into ID/EX
- pending  output  32  bit r = (cnt[r] != 0); bit 0 is always 0
- busy  output  1  OR of pending
- sb_error  output  1  sticky flag: retire seen for a register with cnt = 0

## Operation
- State: cnt[1..31], each CNT_W bits wide. Register 0 is never tracked. Plus the sb_error flop.
- Source hazard on Rs: id_use_rs && id_Rs != 0 && cnt[id_Rs] != 0 && !byp_rs. The same rule applies to Rt.
- Capacity hazard: id_RegWrite && id_long && id_Write_register != 0 && cnt[id_Write_register] == MAX.
- id_stall = id_valid && !flush && (either source hazard || capacity hazard). The signal is combinational from current state and inputs.
- Issue condition: id_valid && !id_stall && !flush && id_RegWrite && id_long && id_Write_register != 0. On issue, cnt[id_Write_register] increments.
- Retire condition: wb_valid && wb_Write_register != 0.
  - If cnt[wb_Write_register] > 0, the counter decrements.
  - If it is 0, the counter is unchanged and sb_error is set.
- Issue and retire on the same register in the same cycle leave the counter unchanged. No error is raised in that case, even if the counter is 0.
- Issue and retire on different registers in the same cycle update both counters independently.
- Non-long writes (ordinary R-type) are never tracked. EX forwarding covers them.
- A stalled instruction is not issued. It is re-evaluated every cycle until its hazard clears.

## Timing
- Reset (reset = 0 at a rising edge): all cnt = 0 and sb_error = 0. While reset is low, id_stall is forced to 0. Outputs after reset: pending = 0, busy = 0, id_stall = 0, sb_error = 0.
- Issue in cycle N: pending and cnt are visible from cycle N+1. A dependent reader in N+1 stalls.
- Retire in cycle N: the counter drops at the end of cycle N.
  - Without bypass, a reader waiting on that register stalls in cycle N and proceeds in N+1.
- The flush input gates both stall and issue in the same cycle, so a flushed instruction never allocates a counter.
- Once the counter drops, id_stall deasserts in the next cycle with no extra bubble.

## Configuration
- SB_BYPASS_EN defined: byp_rs = wb_valid && wb_Write_register == id_Rs && cnt[id_Rs] == 1. The same rule applies to Rt. The reader proceeds in the retire cycle and takes the value via the WB forwarding path.
  - The capacity hazard is not bypassed.
- SB_BYPASS_EN undefined: byp_rs = byp_rt = 0, and readers wait one cycle after retire.

## Test plan
- **Reset:** hold reset = 0 for 2 cycles with random inputs, then release -> pending = 0, busy = 0, sb_error = 0, and id_stall = 0 throughout reset.
- **Load-use:** issue a long write to r8 in cycle 1. In cycle 2, ID reads r8 via Rs. Retire r8 in cycle 4.
  - Without the macro: id_stall = 1 in cycles 2–4 and 0 in cycle 5.
  - With SB_BYPASS_EN: id_stall = 0 in cycle 4.
- **Capacity:** issue three long writes to r5 (CNT_W = 2) with no retire -> cnt = 3. A fourth write to r5 stalls until r5 retires, then issues, and pending[5] stays 1 throughout.
- **Simultaneous events:**
  - Issue to r9 with cnt[r9] = 1 while r9 retires in the same cycle -> cnt[r9] stays 1.
  - Issue to r3 with r4 retiring -> cnt[r3] = 1 and cnt[r4] decremented.
- **Register 0 and flush:**
  - A long write to r0 -> pending stays 0.
  - A reader of r0 never stalls.
  - Issue with flush = 1 -> no counter change, and id_stall = 0.
- **Error and reset mid-operation:** retire r12 with cnt[r12] = 0 -> sb_error = 1 and stays set. With r2 and r7 pending, drive reset low for one edge -> all pending clear and sb_error = 0.
